// File: rtl/kart_motion.sv
// Per-frame kart kinematics: speed, heading and 11.12 fixed-point position.
// The pose is published atomically. Define KART_WRAP_EN to make positions wrap modulo 2048 instead of clamping.
module kart_motion #(
  parameter int START_X   = 1200,
  parameter int START_Y   = 191,
  parameter int START_DIR = 270,
  parameter int ACCEL     = 4,
  parameter int BRAKE     = 8,
  parameter int FRICTION  = 1,
  parameter int MAX_SPEED = 64,
  parameter int TURN_STEP = 3,
  parameter int MAP_MAX   = 2047
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        frame_tick_in,
  input  logic        btn_accel,
  input  logic        btn_brake,
  input  logic        btn_left,
  input  logic        btn_right,
  output logic [10:0] player_x,
  output logic [10:0] player_y,
  output logic [8:0]  direction,
  output logic [7:0]  speed_out,
  output logic        busy,
  output logic        update_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_SPEED, S_TURN, S_TRIG, S_MOVE, S_PUBLISH
  } state_e;

  // Quarter-wave sine, round(256*sin(i deg)) for i = 0..90
  localparam logic [8:0] SIN_LUT [0:90] = '{
    9'd0,   9'd4,   9'd9,   9'd13,  9'd18,  9'd22,  9'd27,  9'd31,  9'd36,  9'd40,
    9'd44,  9'd49,  9'd53,  9'd58,  9'd62,  9'd66,  9'd71,  9'd75,  9'd79,  9'd83,
    9'd88,  9'd92,  9'd96,  9'd100, 9'd104, 9'd108, 9'd112, 9'd116, 9'd120, 9'd124,
    9'd128, 9'd132, 9'd136, 9'd139, 9'd143, 9'd147, 9'd150, 9'd154, 9'd158, 9'd161,
    9'd165, 9'd168, 9'd171, 9'd175, 9'd178, 9'd181, 9'd184, 9'd187, 9'd190, 9'd193,
    9'd196, 9'd199, 9'd202, 9'd204, 9'd207, 9'd210, 9'd212, 9'd215, 9'd217, 9'd219,
    9'd222, 9'd224, 9'd226, 9'd228, 9'd230, 9'd232, 9'd234, 9'd236, 9'd237, 9'd239,
    9'd241, 9'd242, 9'd243, 9'd245, 9'd246, 9'd247, 9'd248, 9'd249, 9'd250, 9'd251,
    9'd252, 9'd253, 9'd254, 9'd254, 9'd255, 9'd255, 9'd255, 9'd256, 9'd256, 9'd256,
    9'd256
  };

  state_e             state_q, state_d;
  logic [3:0]         btn_q, btn_d;      // {accel, brake, left, right}
  logic [7:0]         speed_q, speed_d;
  logic [8:0]         dir_q, dir_d;
  logic signed [16:0] dx_q, dx_d, dy_q, dy_d;
  logic [22:0]        xpos_q, xpos_d, ypos_q, ypos_d;
  logic [10:0]        x_out_q, x_out_d, y_out_q, y_out_d;
  logic [8:0]         dir_out_q, dir_out_d;
  logic [7:0]         spd_out_q, spd_out_d;
  logic               done_q, done_d;

  logic [6:0]         s_idx, c_idx;
  logic               s_neg, c_neg;
  logic [16:0]        s_mag, c_mag;
  logic [16:0]        dx_calc, dy_calc;
  int                 sp_tmp, hd_tmp;

  // Signed add with sign and guard bits, then clamp or wrap to the 11.12 range
  function automatic logic [22:0] move_pos(input logic [22:0] p, input logic [16:0] d);
    logic signed [24:0] sum;
    sum = $signed({2'b00, p}) + $signed({{8{d[16]}}, d});
`ifdef KART_WRAP_EN
    return sum[22:0];
`else
    if (sum < 0)
      return '0;
    else if (sum[24:12] > 13'(MAP_MAX))
      return {11'(MAP_MAX), 12'b0};
    else
      return sum[22:0];
`endif
  endfunction

  // Fold the heading into the first quadrant and pick signs for sin/cos
  always_comb begin
    s_idx = '0;
    c_idx = '0;
    s_neg = 1'b0;
    c_neg = 1'b0;
    if (dir_q < 9'd90) begin
      s_idx = 7'(dir_q);
      c_idx = 7'(9'd90 - dir_q);
    end else if (dir_q < 9'd180) begin
      s_idx = 7'(9'd180 - dir_q);
      c_idx = 7'(dir_q - 9'd90);
      c_neg = 1'b1;
    end else if (dir_q < 9'd270) begin
      s_idx = 7'(dir_q - 9'd180);
      c_idx = 7'(9'd270 - dir_q);
      s_neg = 1'b1;
      c_neg = 1'b1;
    end else begin
      s_idx = 7'(9'd360 - dir_q);
      c_idx = 7'(dir_q - 9'd270);
      s_neg = 1'b1;
    end
  end

  assign s_mag   = 17'(speed_q) * 17'(SIN_LUT[s_idx]);
  assign c_mag   = 17'(speed_q) * 17'(SIN_LUT[c_idx]);
  assign dx_calc = c_neg ? (17'd0 - c_mag) : c_mag;
  assign dy_calc = s_neg ? s_mag : (17'd0 - s_mag);

  always_comb begin
    state_d   = state_q;
    btn_d     = btn_q;
    speed_d   = speed_q;
    dir_d     = dir_q;
    dx_d      = dx_q;
    dy_d      = dy_q;
    xpos_d    = xpos_q;
    ypos_d    = ypos_q;
    x_out_d   = x_out_q;
    y_out_d   = y_out_q;
    dir_out_d = dir_out_q;
    spd_out_d = spd_out_q;
    done_d    = 1'b0;
    sp_tmp    = int'(speed_q);
    hd_tmp    = int'(dir_q);
    case (state_q)
      S_IDLE: begin
        if (frame_tick_in) begin
          btn_d   = {btn_accel, btn_brake, btn_left, btn_right};
          state_d = S_SPEED;
        end
      end
      S_SPEED: begin
        if (btn_q[2])      sp_tmp = sp_tmp - BRAKE;
        else if (btn_q[3]) sp_tmp = sp_tmp + ACCEL;
        else               sp_tmp = sp_tmp - FRICTION;
        if (sp_tmp < 0)              sp_tmp = 0;
        else if (sp_tmp > MAX_SPEED) sp_tmp = MAX_SPEED;
        speed_d = 8'(sp_tmp);
        state_d = S_TURN;
      end
      S_TURN: begin
        if (btn_q[1] && !btn_q[0])      hd_tmp = hd_tmp + TURN_STEP;
        else if (btn_q[0] && !btn_q[1]) hd_tmp = hd_tmp - TURN_STEP;
        if (hd_tmp >= 360)   hd_tmp = hd_tmp - 360;
        else if (hd_tmp < 0) hd_tmp = hd_tmp + 360;
        dir_d   = 9'(hd_tmp);
        state_d = S_TRIG;
      end
      S_TRIG: begin
        dx_d    = dx_calc;
        dy_d    = dy_calc;
        state_d = S_MOVE;
      end
      S_MOVE: begin
        xpos_d  = move_pos(xpos_q, dx_q);
        ypos_d  = move_pos(ypos_q, dy_q);
        state_d = S_PUBLISH;
      end
      S_PUBLISH: begin
        x_out_d   = xpos_q[22:12];
        y_out_d   = ypos_q[22:12];
        dir_out_d = dir_q;
        spd_out_d = speed_q;
        done_d    = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= S_IDLE;
      btn_q     <= '0;
      speed_q   <= '0;
      dir_q     <= 9'(START_DIR);
      dx_q      <= '0;
      dy_q      <= '0;
      xpos_q    <= {11'(START_X), 12'b0};
      ypos_q    <= {11'(START_Y), 12'b0};
      x_out_q   <= 11'(START_X);
      y_out_q   <= 11'(START_Y);
      dir_out_q <= 9'(START_DIR);
      spd_out_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      btn_q     <= btn_d;
      speed_q   <= speed_d;
      dir_q     <= dir_d;
      dx_q      <= dx_d;
      dy_q      <= dy_d;
      xpos_q    <= xpos_d;
      ypos_q    <= ypos_d;
      x_out_q   <= x_out_d;
      y_out_q   <= y_out_d;
      dir_out_q <= dir_out_d;
      spd_out_q <= spd_out_d;
      done_q    <= done_d;
    end
  end

  assign player_x    = x_out_q;
  assign player_y    = y_out_q;
  assign direction   = dir_out_q;
  assign speed_out   = spd_out_q;
  assign busy        = (state_q != S_IDLE);
  assign update_done = done_q;

endmodule

// File: tb/tb_kart_motion.sv
// Bench for kart_motion: four differently parameterised instances share one stimulus
// and are each compared against a real-arithmetic kinematics model.
module tb_kart_motion;
  localparam int N = 4;
  localparam int MAP_MAX = 2047;
  localparam int SX0 = 1200, SY0 = 191,  SD0 = 270, AC0 = 4;
  localparam int SX1 = 2046, SY1 = 191,  SD1 = 0,   AC1 = 64;
  localparam int SX2 = 1,    SY2 = 1000, SD2 = 180, AC2 = 64;
  localparam int SX3 = 1200, SY3 = 191,  SD3 = 358, AC3 = 4;

  int p_sx [N] = '{SX0, SX1, SX2, SX3};
  int p_sy [N] = '{SY0, SY1, SY2, SY3};
  int p_sd [N] = '{SD0, SD1, SD2, SD3};
  int p_ac [N] = '{AC0, AC1, AC2, AC3};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, tick = 1'b0, ba = 1'b0, bb = 1'b0, bl = 1'b0, br = 1'b0;
  logic [10:0] px [N];
  logic [10:0] py [N];
  logic [8:0]  pd [N];
  logic [7:0]  ps [N];
  logic        bz [N];
  logic        ud [N];

  kart_motion #(.START_X(SX0), .START_Y(SY0), .START_DIR(SD0), .ACCEL(AC0)) u_dut0 (
    .clk_in(clk), .rst_in(rst), .frame_tick_in(tick), .btn_accel(ba), .btn_brake(bb),
    .btn_left(bl), .btn_right(br), .player_x(px[0]), .player_y(py[0]), .direction(pd[0]),
    .speed_out(ps[0]), .busy(bz[0]), .update_done(ud[0]));
  kart_motion #(.START_X(SX1), .START_Y(SY1), .START_DIR(SD1), .ACCEL(AC1)) u_dut1 (
    .clk_in(clk), .rst_in(rst), .frame_tick_in(tick), .btn_accel(ba), .btn_brake(bb),
    .btn_left(bl), .btn_right(br), .player_x(px[1]), .player_y(py[1]), .direction(pd[1]),
    .speed_out(ps[1]), .busy(bz[1]), .update_done(ud[1]));
  kart_motion #(.START_X(SX2), .START_Y(SY2), .START_DIR(SD2), .ACCEL(AC2)) u_dut2 (
    .clk_in(clk), .rst_in(rst), .frame_tick_in(tick), .btn_accel(ba), .btn_brake(bb),
    .btn_left(bl), .btn_right(br), .player_x(px[2]), .player_y(py[2]), .direction(pd[2]),
    .speed_out(ps[2]), .busy(bz[2]), .update_done(ud[2]));
  kart_motion #(.START_X(SX3), .START_Y(SY3), .START_DIR(SD3), .ACCEL(AC3)) u_dut3 (
    .clk_in(clk), .rst_in(rst), .frame_tick_in(tick), .btn_accel(ba), .btn_brake(bb),
    .btn_left(bl), .btn_right(br), .player_x(px[3]), .player_y(py[3]), .direction(pd[3]),
    .speed_out(ps[3]), .busy(bz[3]), .update_done(ud[3]));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: speed, heading in degrees, positions in units of 2^-12 px
  int     m_sp  [N];
  int     m_dir [N];
  longint m_x   [N];
  longint m_y   [N];

  function automatic int q8(input real v);
    if (v >= 0.0) return $rtoi(v * 256.0 + 0.5);
    else          return -$rtoi(-v * 256.0 + 0.5);
  endfunction

  function automatic longint mv(input longint p, input longint d);
    longint s;
    s = p + d;
`ifdef KART_WRAP_EN
    s = s % 64'sd8388608;
    if (s < 0) s = s + 64'sd8388608;
    return s;
`else
    if (s < 0) return 0;
    if (s / 4096 > MAP_MAX) return longint'(MAP_MAX) * 4096;
    return s;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_sp[i]  = 0;
      m_dir[i] = p_sd[i];
      m_x[i]   = longint'(p_sx[i]) * 4096;
      m_y[i]   = longint'(p_sy[i]) * 4096;
    end
  endtask

  task automatic model_frame(input bit a, input bit b, input bit l, input bit r);
    real ang;
    for (int i = 0; i < N; i++) begin
      if (b)      m_sp[i] = m_sp[i] - 8;
      else if (a) m_sp[i] = m_sp[i] + p_ac[i];
      else        m_sp[i] = m_sp[i] - 1;
      if (m_sp[i] < 0)  m_sp[i] = 0;
      if (m_sp[i] > 64) m_sp[i] = 64;
      if (l && !r)      m_dir[i] = (m_dir[i] + 3) % 360;
      else if (r && !l) m_dir[i] = (m_dir[i] + 357) % 360;
      ang = real'(m_dir[i]) * 3.141592653589793 / 180.0;
      m_x[i] = mv(m_x[i], longint'(m_sp[i] * q8($cos(ang))));
      m_y[i] = mv(m_y[i], longint'(-m_sp[i] * q8($sin(ang))));
    end
  endtask

  task automatic check_pose(input string tag);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("%s_x%0d", tag, i),   int'(px[i]), int'(m_x[i] / 4096));
      chk($sformatf("%s_y%0d", tag, i),   int'(py[i]), int'(m_y[i] / 4096));
      chk($sformatf("%s_dir%0d", tag, i), int'(pd[i]), m_dir[i]);
      chk($sformatf("%s_spd%0d", tag, i), int'(ps[i]), m_sp[i]);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; tick = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    chk("rst_x", int'(px[0]), 1200);
    chk("rst_y", int'(py[0]), 191);
    chk("rst_dir", int'(pd[0]), 270);
    chk("rst_spd", int'(ps[0]), 0);
    chk("rst_busy", int'(bz[0]), 0);
    chk("rst_done", int'(ud[0]), 0);
    check_pose("rst");
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One frame; xt>0 raises an extra tick after edge xt, which must be ignored
  task automatic frame(input bit a, input bit b, input bit l, input bit r, input int xt);
    @(negedge clk);
    ba = a; bb = b; bl = l; br = r; tick = 1'b1;
    @(posedge clk);
    #1;
    tick = 1'b0;
    {ba, bb, bl, br} = 4'($urandom);
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      #1;
      tick = (k == xt);
      if (k < 5) begin
        chk("busy", int'(bz[0]), 1);
        chk("done_early", int'(ud[0]), 0);
        chk("x_hold", int'(px[0]), int'(m_x[0] / 4096));
        chk("spd_hold", int'(ps[0]), m_sp[0]);
      end
    end
    model_frame(a, b, l, r);
    for (int i = 0; i < N; i++) chk($sformatf("done%0d", i), int'(ud[i]), 1);
    check_pose("pose");
    @(posedge clk);
    #1;
    chk("done_pulse", int'(ud[0]), 0);
    chk("busy_after", int'(bz[0]), 0);
    if (xt != 0) begin
      repeat (7) begin
        @(posedge clk);
        #1;
        chk("extra_done", int'(ud[0]), 0);
        chk("extra_busy", int'(bz[0]), 0);
      end
      chk("extra_y", int'(py[0]), int'(m_y[0] / 4096));
    end
  endtask

  task automatic frame_rst();
    @(negedge clk);
    ba = 1'b1; bb = 1'b0; bl = 1'b1; br = 1'b0; tick = 1'b1;
    @(posedge clk);
    #1;
    tick = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    chk("mid_rst_busy", int'(bz[0]), 0);
    check_pose("mid_rst");
    repeat (6) begin
      @(posedge clk);
      #1;
      chk("mid_rst_done", int'(ud[0]), 0);
      chk("mid_rst_x", int'(px[0]), 1200);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    do_reset();

    for (int n = 1; n <= 4; n++) begin
      frame(1, 0, 0, 0, 0);
      chk("acc_spd", int'(ps[0]), 4 * n);
      if (n == 1) begin
`ifdef KART_WRAP_EN
        chk("edge_hi", int'(px[1]), 2);
        chk("edge_lo", int'(px[2]), 2045);
`else
        chk("edge_hi", int'(px[1]), 2047);
        chk("edge_lo", int'(px[2]), 0);
`endif
      end
    end
    chk("acc_y", int'(py[0]), 193);
    chk("acc_x", int'(px[0]), 1200);

    do_reset();
    frame(0, 0, 1, 0, 0);
    chk("wrap_left", int'(pd[3]), 1);
    frame(0, 0, 0, 1, 0);
    chk("wrap_right", int'(pd[3]), 358);
    frame(0, 0, 1, 1, 0);
    chk("turn_both", int'(pd[3]), 358);

    do_reset();
    frame(1, 0, 0, 0, 0); frame(1, 0, 0, 0, 0); frame(1, 0, 0, 0, 0);
    frame(0, 0, 0, 0, 0); frame(0, 0, 0, 0, 0);
    chk("spd10", int'(ps[0]), 10);
    frame(1, 1, 0, 0, 0);
    chk("acc_brk", int'(ps[0]), 2);
    frame(1, 0, 0, 0, 0); frame(0, 0, 0, 0, 0);
    chk("spd5", int'(ps[0]), 5);
    frame(0, 1, 0, 0, 0);
    chk("brk_floor", int'(ps[0]), 0);
    frame(1, 0, 0, 0, 0); frame(0, 0, 0, 0, 0);
    chk("spd3", int'(ps[0]), 3);
    frame(0, 0, 0, 0, 0);
    chk("coast", int'(ps[0]), 2);
    for (int n = 0; n < 15; n++) frame(1, 0, 0, 0, 0);
    chk("spd62", int'(ps[0]), 62);
    frame(1, 0, 0, 0, 0);
    chk("acc_ceil", int'(ps[0]), 64);

    frame(1, 0, 1, 0, 1);
    frame_rst();

    for (int n = 0; n < 300; n++) begin
      bit a, b, l, r;
      int xt;
      a  = ($urandom_range(0, 99) < 60);
      b  = ($urandom_range(0, 99) < 15);
      l  = ($urandom_range(0, 99) < 35);
      r  = ($urandom_range(0, 99) < 30);
      xt = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0;
      frame(a, b, l, r, xt);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/kart_motion.md
# kart_motion

Per-frame kinematics engine for the player kart: on every frame tick it samples the driver buttons, updates speed and heading, and integrates the kart position in fixed point. It is the producer of the `player_x` / `player_y` / `direction` state consumed by `forward_view`, and it publishes all three atomically, once per frame, so the renderer never sees a half-updated pose. It sits between the button debouncers and the renderer and is clocked by the pixel clock.

## Interface
Parameters:
- `START_X`, default 1200: x position loaded on reset, in pixels.
- `START_Y`, default 191: y position loaded on reset, in pixels.
- `START_DIR`, default 270: heading loaded on reset, in degrees, range 0..359.
- `ACCEL`, default 4: speed increment per frame while accelerating.
- `BRAKE`, default 8: speed decrement per frame while braking.
- `FRICTION`, default 1: speed decrement per frame while coasting.
- `MAX_SPEED`, default 64: speed ceiling, in units of 1/16 px per frame.
- `TURN_STEP`, default 3: heading change per frame, in degrees.
- `MAP_MAX`, default 2047: largest legal position coordinate on either axis.

Ports (clock and reset first):
- `clk_in`  in  1  pixel clock.
- `rst_in`  in  1  reset; synchronous, active-high.
- `frame_tick_in`  in  1  one-cycle pulse, once per frame.
- `btn_accel`  in  1  accelerate request, level.
- `btn_brake`  in  1  brake request, level.
- `btn_left`  in  1  turn-left request, level.
- `btn_right`  in  1  turn-right request, level.
- `player_x`  out  11  integer x position.
- `player_y`  out  11  integer y position.
- `direction`  out  9  heading in degrees, always 0..359.
- `speed_out`  out  8  current speed.
- `busy`  out  1  high while an update is in progress.
- `update_done`  out  1  one-cycle pulse marking a new pose.

## Operation
- **Reset:** `player_x` = START_X, `player_y` = START_Y, `direction` = START_DIR; speed, fractions, `busy` and `update_done` are all 0.
- **FSM states:** IDLE → SPEED → TURN → TRIG → MOVE → PUBLISH → IDLE.
- **IDLE:** on `frame_tick_in`, latch the four buttons and leave IDLE.
- **SPEED:**
  - If brake is pressed: speed −= BRAKE. Brake wins over accel.
  - Else if accel is pressed: speed += ACCEL.
  - Otherwise: speed −= FRICTION.
  - The result saturates to the range 0..MAX_SPEED.
- **TURN:**
  - Left alone: heading += TURN_STEP.
  - Right alone: heading −= TURN_STEP.
  - Both or neither: no change.
  - The heading is taken modulo 360, so 358+3 → 1 and 1−3 → 358.
- **TRIG:**
  - A quarter-wave LUT with 91 entries gives sin and cos in Q0.8 (0..256), with the sign chosen by quadrant.
  - dx = speed·cos(dir); dy = −speed·sin(dir). Heading 90 therefore points up the screen and 270 points down.
- **MOVE:**
  - Internal positions are 11.12 unsigned fixed point, and each delta is in units of 2^-12 px.
  - The add is done signed, with 1 guard bit.
  - If the result is below 0: integer = 0, fraction = 0.
  - If the result is above MAP_MAX: integer = MAP_MAX, fraction = 0.
- **PUBLISH:** the new speed, heading and integer positions are registered to the outputs on the same edge, and `update_done` pulses for 1 cycle.
- The new speed and the new heading are both used by the MOVE of the same frame.

## Timing
- A tick sampled at edge 0 gives `busy` high from edge 1 to edge 5.
- Outputs change, and `update_done` is high, for the cycle after edge 5. Latency is 5 cycles.
- Outputs are stable at every other time.
- A `frame_tick_in` that arrives while `busy` is high is ignored: it is not queued and no error is flagged.
- Buttons are sampled only in the tick cycle. Button changes during an update have no effect.
- Reset asserted mid-update: on the next edge the FSM returns to IDLE and all outputs return to their reset values. No `update_done` is produced.
- Outputs stay constant between frames.

## Configuration
- `KART_WRAP_EN` defined:
  - Positions wrap modulo 2048 instead of clamping, and the fraction is preserved.
  - MAP_MAX is unused.
  - Example: 2046 + 4 → 2, and 1 − 4 → 2045.
- `KART_WRAP_EN` undefined: the clamp behaviour described under MOVE applies.

## Test plan
- **Reset values:** assert `rst_in` for 2 cycles → `player_x` = 1200, `player_y` = 191, `direction` = 270, `speed_out` = 0, `busy` = 0, `update_done` = 0.
- **Acceleration and latency:**
  - Stimulus: `btn_accel` held for 4 ticks at heading 270.
  - Speed: 4, 8, 12, 16.
  - Position: `player_y` = 193 after tick 4 (2.5 px accumulated); `player_x` stays 1200.
  - Latency: `update_done` rises exactly 5 cycles after each tick.
- **Heading wrap:**
  - `btn_left` from 358 → 1.
  - `btn_right` from 1 → 358.
  - Left and right together → no change.
- **Boundary at MAP_MAX:**
  - Stimulus: x = 2046, heading 0, speed 64.
  - Default build → x = 2047.
  - Build with `KART_WRAP_EN` → x = 2.
  - Heading 180 from x = 1 → 0 (wrap build: 2045).
- **Speed rules:**
  - Accel and brake together at speed 10 → 2.
  - Brake at speed 5 → 0.
  - Coasting at speed 3 → 2.
  - Accel at speed 62 → 64.
- **Tick during busy and reset mid-update:**
  - A second tick 2 cycles after the first → only one `update_done`.
  - `rst_in` at edge 3 of an update → outputs reset and no `update_done` pulse.
